ram_arbiter: RTL and testbench

Shares the CPU's single-port 4-bit × 4096 RAM between the register-file memory port (`regs` memory_addr/write_en/write_data/read_data) and a host port used for save-state and debug access. The CPU port always has priority. Host accesses are slotted into cycles where the microcode sequencer is idle (CYCLE_NONE). A starvation counter forces a hold on the sequencer if the host waits too long. The block sits between `regs` and the RAM macro, and its hold output feeds the microcode sequencer.

---
 rtl/ram_arbiter.sv | 150 +++++++++++++++
 tb/tb_ram_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares the CPU's single-port 4-bit x 4096 RAM between the
// register-file memory port and a host (save-state / debug) port.
//   CPU side : cpu_idle, cpu_begin, cpu_hold (to sequencer),
//              cpu_addr / cpu_write_en / cpu_write_data / cpu_read_data
//   Host side: host_req (level), host_we, host_addr, host_wdata,
//              host_ack (1-cycle pulse), host_rdata (held until next ack)
//   RAM side : ram_addr, ram_we, ram_wdata, ram_rdata (1-cycle sync read)
// The CPU always wins; host accesses are slotted into idle sequencer cycles,
// and a starvation counter raises cpu_hold when the host waits too long.
module ram_arbiter #(
  parameter  int unsigned STARVE_LIMIT = 15,
  localparam int unsigned ADDR_W       = 12,
  localparam int unsigned DATA_W       = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_idle,
  input  logic              cpu_begin,
  output logic              cpu_hold,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_write_en,
  input  logic [DATA_W-1:0] cpu_write_data,
  output logic [DATA_W-1:0] cpu_read_data,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DATA  = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  wait_cnt, wait_cnt_nxt;
  logic              cpu_hold_nxt;
  logic              host_ack_nxt;
  logic [DATA_W-1:0] host_rdata_nxt;
  logic              grant_c;

  // Host request captured at grant so a granted access completes even if
  // the host drops or changes its request mid-transaction.
  logic              txn_we;
  logic [ADDR_W-1:0] txn_addr;
  logic [DATA_W-1:0] txn_wdata;

  // CPU read data is a pure passthrough: no added latency on the CPU path.
  assign cpu_read_data = ram_rdata;

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      cpu_hold   <= 1'b0;
      host_ack   <= 1'b0;
      host_rdata <= '0;
      txn_we     <= 1'b0;
      txn_addr   <= '0;
      txn_wdata  <= '0;
    end else begin
      state      <= state_nxt;
      wait_cnt   <= wait_cnt_nxt;
      cpu_hold   <= cpu_hold_nxt;
      host_ack   <= host_ack_nxt;
      host_rdata <= host_rdata_nxt;
      if (grant_c) begin
        txn_we    <= host_we;
        txn_addr  <= host_addr;
        txn_wdata <= host_wdata;
      end
    end
  end

  // Next-state, starvation counter and RAM port mux.
  always_comb begin
    state_nxt      = state;
    wait_cnt_nxt   = wait_cnt;
    cpu_hold_nxt   = cpu_hold;
    host_ack_nxt   = 1'b0;
    host_rdata_nxt = host_rdata;
    grant_c        = 1'b0;
    ram_addr       = cpu_addr;
    ram_we         = cpu_write_en;
    ram_wdata      = cpu_write_data;

    case (state)
      IDLE: begin
        // The ack cycle never grants, which gives the 4-cycle host cadence.
        grant_c = host_req && !host_ack && cpu_idle && (cpu_hold || !cpu_begin);
        if (grant_c) begin
          state_nxt    = ISSUE;
          wait_cnt_nxt = '0;
        end else if (host_req && !host_ack) begin
          if (wait_cnt < LIMIT_C) begin
            wait_cnt_nxt = wait_cnt + CNT_W'(1);
          end
          if (wait_cnt_nxt == LIMIT_C) begin
            cpu_hold_nxt = 1'b1;
          end
        end else if (!host_req) begin
          // A withdrawn request must not leave the sequencer stuck on hold.
          cpu_hold_nxt = 1'b0;
        end
      end
      ISSUE: begin
        ram_addr  = txn_addr;
        ram_we    = txn_we;
        ram_wdata = txn_wdata;
        state_nxt = DATA;
      end
      DATA: begin
        ram_addr     = txn_addr;
        ram_we       = 1'b0;
        ram_wdata    = txn_wdata;
        state_nxt    = IDLE;
        host_ack_nxt = 1'b1;
        cpu_hold_nxt = 1'b0;
        wait_cnt_nxt = '0;
        if (!txn_we) begin
          host_rdata_nxt = ram_rdata;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    if (!host_req) begin
      wait_cnt_nxt = '0;
    end

    // No RAM writes of any kind while reset is asserted.
    if (reset) begin
      ram_we = 1'b0;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
module tb_ram_arbiter;

  localparam int unsigned LIMIT = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_idle, cpu_begin, cpu_hold;
  logic [11:0] cpu_addr;
  logic        cpu_write_en;
  logic [3:0]  cpu_write_data, cpu_read_data;
  logic        host_req, host_we, host_ack;
  logic [11:0] host_addr;
  logic [3:0]  host_wdata, host_rdata;
  logic [11:0] ram_addr;
  logic        ram_we;
  logic [3:0]  ram_wdata, ram_rdata;

  ram_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .cpu_idle(cpu_idle), .cpu_begin(cpu_begin), .cpu_hold(cpu_hold),
    .cpu_addr(cpu_addr), .cpu_write_en(cpu_write_en),
    .cpu_write_data(cpu_write_data), .cpu_read_data(cpu_read_data),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // RAM macro model with a backdoor port for preloading.
  logic [3:0]  mem [4096];
  logic        bd_en;
  logic [11:0] bd_addr;
  logic [3:0]  bd_data;
  always @(posedge clk) begin
    if (bd_en) mem[bd_addr] <= bd_data;
    else if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  // Reference: what each address should hold after the accesses issued.
  logic [3:0] exp_mem [4096];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle_cpu();
    cpu_idle     = 1'b1;
    cpu_begin    = 1'b0;
    cpu_write_en = 1'b0;
  endtask

  // Host transaction with an idle CPU: ack must come exactly 3 cycles after req.
  task automatic host_txn(input logic we, input logic [11:0] a, input logic [3:0] d,
                          output logic [3:0] rd);
    int lat;
    bit done;
    host_req = 1'b1; host_we = we; host_addr = a; host_wdata = d;
    lat = 0; done = 0; rd = 4'h0;
    settle();
    while (!done && lat < 50) begin
      if (host_ack) begin
        done = 1;
        rd = host_rdata;
      end else begin
        next_cycle(); settle(); lat++;
      end
    end
    chk("rnd_latency", 32'(lat), 32'd3);
    next_cycle(); host_req = 1'b0; settle();
    chk("rnd_ack_pulse", 32'(host_ack), 32'd0);
  endtask

  logic [11:0] ra;
  logic [3:0]  rdv, rd;
  int          op, gc;
  bit          busy;
  logic        e_hold, e_ack, e_host;

  initial begin
    reset = 1'b1; bd_en = 1'b0; bd_addr = '0; bd_data = '0;
    idle_cpu(); cpu_addr = '0; cpu_write_data = '0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;

    for (int a = 0; a < 4096; a++) exp_mem[a] = 4'(a * 7 + 3);
    exp_mem[12'h2FF] = 4'hA;
    next_cycle();
    for (int a = 0; a < 4096; a++) begin
      bd_en = 1'b1; bd_addr = 12'(a); bd_data = exp_mem[a];
      next_cycle();
    end
    bd_en = 1'b0;

    // Reset state; a CPU write attempted under reset must be blocked.
    cpu_write_en = 1'b1; cpu_addr = 12'h0AB; cpu_write_data = 4'h5;
    settle();
    chk("rst_ram_we", 32'(ram_we), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'h0AB);
    chk("rst_hold", 32'(cpu_hold), 32'd0);
    chk("rst_ack", 32'(host_ack), 32'd0);
    chk("rst_rdata", 32'(host_rdata), 32'd0);
    next_cycle(); idle_cpu(); reset = 1'b0; cpu_addr = 12'h000;

    // Host read 0x2FF with idle CPU.
    next_cycle(); host_req = 1'b1; host_we = 1'b0; host_addr = 12'h2FF; settle();
    chk("t1_c0_addr", 32'(ram_addr), 32'h000);
    chk("t1_c0_ack", 32'(host_ack), 32'd0);
    next_cycle(); settle();
    chk("t1_c1_addr", 32'(ram_addr), 32'h2FF);
    chk("t1_c1_we", 32'(ram_we), 32'd0);
    next_cycle(); settle();
    chk("t1_c2_addr", 32'(ram_addr), 32'h2FF);
    chk("t1_c2_ack", 32'(host_ack), 32'd0);
    next_cycle(); settle();
    chk("t1_c3_ack", 32'(host_ack), 32'd1);
    chk("t1_c3_rdata", 32'(host_rdata), 32'hA);
    next_cycle(); host_req = 1'b0; settle();
    chk("t1_c4_ack", 32'(host_ack), 32'd0);
    chk("t1_c4_rdata", 32'(host_rdata), 32'hA);

    // Host write 0x345 <- 0x4, then CPU reads it back.
    next_cycle(); host_req = 1'b1; host_we = 1'b1; host_addr = 12'h345; host_wdata = 4'h4; settle();
    chk("t2_c0_we", 32'(ram_we), 32'd0);
    next_cycle(); settle();
    chk("t2_c1_addr", 32'(ram_addr), 32'h345);
    chk("t2_c1_we", 32'(ram_we), 32'd1);
    chk("t2_c1_wdata", 32'(ram_wdata), 32'h4);
    next_cycle(); settle();
    chk("t2_c2_we", 32'(ram_we), 32'd0);
    next_cycle(); settle();
    chk("t2_c3_ack", 32'(host_ack), 32'd1);
    chk("t2_c3_rdata_kept", 32'(host_rdata), 32'hA);
    exp_mem[12'h345] = 4'h4;
    next_cycle(); host_req = 1'b0; cpu_addr = 12'h345; settle();
    chk("t2_c4_ack", 32'(host_ack), 32'd0);
    chk("t2_c4_addr", 32'(ram_addr), 32'h345);
    next_cycle(); settle();
    chk("t2_c5_cpu_rd", 32'(cpu_read_data), 32'(exp_mem[12'h345]));

    // Busy CPU (begin whenever idle, 1 busy cycle): starvation hold.
    // Hold rises LIMIT cycles after req; grant at the first idle cycle after.
    gc = int'(LIMIT) + int'(LIMIT % 2);
    busy = 0;
    next_cycle(); cpu_addr = 12'h050; host_we = 1'b0; host_addr = 12'h123; host_req = 1'b1;
    for (int c = 0; c <= gc + 4; c++) begin
      if (c > 0) next_cycle();
      cpu_idle = !busy; cpu_begin = !busy;
      if (c == gc + 4) host_req = 1'b0;
      settle();
      e_hold = (c >= int'(LIMIT)) && (c < gc + 3);
      e_ack  = (c == gc + 3);
      e_host = (c == gc + 1) || (c == gc + 2);
      chk($sformatf("t3_c%0d_hold", c), 32'(cpu_hold), 32'(e_hold));
      chk($sformatf("t3_c%0d_ack", c), 32'(host_ack), 32'(e_ack));
      chk($sformatf("t3_c%0d_addr", c), 32'(ram_addr), e_host ? 32'h123 : 32'h050);
      if (e_ack) chk("t3_rdata", 32'(host_rdata), 32'(exp_mem[12'h123]));
      busy = !busy && !cpu_hold;
    end
    idle_cpu();

    // CPU write 0xF to 0x0F7 while host waits; host reads it back.
    next_cycle(); cpu_idle = 1'b0; cpu_write_en = 1'b1; cpu_addr = 12'h0F7; cpu_write_data = 4'hF;
    host_req = 1'b1; host_we = 1'b0; host_addr = 12'h0F7; settle();
    chk("t4_c0_addr", 32'(ram_addr), 32'h0F7);
    chk("t4_c0_we", 32'(ram_we), 32'd1);
    chk("t4_c0_wdata", 32'(ram_wdata), 32'hF);
    exp_mem[12'h0F7] = 4'hF;
    next_cycle(); cpu_idle = 1'b1; cpu_begin = 1'b1; cpu_write_en = 1'b0; cpu_addr = 12'h010; settle();
    chk("t4_c1_addr", 32'(ram_addr), 32'h010);
    next_cycle(); cpu_idle = 1'b0; cpu_begin = 1'b0; settle();
    chk("t4_c2_addr", 32'(ram_addr), 32'h010);
    next_cycle(); cpu_idle = 1'b1; settle();
    chk("t4_c3_addr", 32'(ram_addr), 32'h010);
    next_cycle(); settle();
    chk("t4_c4_addr", 32'(ram_addr), 32'h0F7);
    chk("t4_c4_we", 32'(ram_we), 32'd0);
    next_cycle(); settle();
    chk("t4_c5_ack", 32'(host_ack), 32'd0);
    next_cycle(); settle();
    chk("t4_c6_ack", 32'(host_ack), 32'd1);
    chk("t4_c6_rdata", 32'(host_rdata), 32'(exp_mem[12'h0F7]));
    next_cycle(); host_req = 1'b0; settle();
    chk("t4_c7_ack", 32'(host_ack), 32'd0);

    // Reset during DATA aborts; the still-pending host is re-served.
    next_cycle(); host_req = 1'b1; host_we = 1'b0; host_addr = 12'h345; settle();
    next_cycle(); settle();
    chk("t5_c1_addr", 32'(ram_addr), 32'h345);
    next_cycle(); reset = 1'b1; settle();
    chk("t5_c2_ack", 32'(host_ack), 32'd0);
    chk("t5_c2_hold", 32'(cpu_hold), 32'd0);
    chk("t5_c2_rdata", 32'(host_rdata), 32'd0);
    chk("t5_c2_addr", 32'(ram_addr), 32'h010);
    next_cycle(); reset = 1'b0; settle();
    chk("t5_c3_ack", 32'(host_ack), 32'd0);
    next_cycle(); settle();
    chk("t5_c4_addr", 32'(ram_addr), 32'h345);
    next_cycle(); settle();
    chk("t5_c5_ack", 32'(host_ack), 32'd0);
    next_cycle(); settle();
    chk("t5_c6_ack", 32'(host_ack), 32'd1);
    chk("t5_c6_rdata", 32'(host_rdata), 32'(exp_mem[12'h345]));
    next_cycle(); host_req = 1'b0; settle();

    // host_req held through ack: 4-cycle cadence.
    next_cycle(); host_req = 1'b1; host_we = 1'b0; host_addr = 12'h2FF;
    for (int c = 0; c <= 8; c++) begin
      if (c > 0) next_cycle();
      if (c == 8) host_req = 1'b0;
      settle();
      e_ack  = (c == 3) || (c == 7);
      e_host = (c == 1) || (c == 2) || (c == 5) || (c == 6);
      chk($sformatf("t6_c%0d_ack", c), 32'(host_ack), 32'(e_ack));
      chk($sformatf("t6_c%0d_addr", c), 32'(ram_addr), e_host ? 32'h2FF : 32'h010);
    end

    // Randomised mix of CPU and host accesses against the shadow memory.
    for (int i = 0; i < 60; i++) begin
      op  = int'($urandom_range(0, 3));
      ra  = ($urandom_range(0, 1) == 1) ? {8'h10, 4'($urandom)} : 12'($urandom);
      rdv = 4'($urandom);
      next_cycle();
      case (op)
        0: begin
          cpu_idle = 1'b0; cpu_write_en = 1'b1; cpu_addr = ra; cpu_write_data = rdv; settle();
          chk("rnd_cpu_we", 32'(ram_we), 32'd1);
          chk("rnd_cpu_addr", 32'(ram_addr), 32'(ra));
          exp_mem[ra] = rdv;
          next_cycle(); idle_cpu();
        end
        1: begin
          cpu_addr = ra;
          next_cycle(); settle();
          chk("rnd_cpu_rd", 32'(cpu_read_data), 32'(exp_mem[ra]));
        end
        2: begin
          host_txn(1'b1, ra, rdv, rd);
          exp_mem[ra] = rdv;
        end
        default: begin
          host_txn(1'b0, ra, 4'h0, rd);
          chk("rnd_host_rd", 32'(rd), 32'(exp_mem[ra]));
        end
      endcase
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
